stage_mem_seq: RTL and testbench
================================

STAGE_MEM_SEQ -- requirements
Module: stage_mem_seq

Interface
REQ-001 SHALL have parameters (name, default, meaning): ADDR_W, 32, address width; DATA_W, 32, register data width (multiple of 8); RAM_LAT, 2, byte-RAM read latency in cycles (>=1); STORE_BUF, 1, 1 = posted one-entry store buffer, 0 = blocking stores.
REQ-002 SHALL have ports (name direction width meaning):
clk input 1 clock, rising edge;
reset input 1 asynchronous, active-high;
load input 1 load request;
store input 1 store request;
addr input ADDR_W byte address;
data input DATA_W store data;
length input 3 byte count;
signed_ input 1 sign-extend load;
write_i input 1 register-write enable;
regw_addr_i input 5 destination register;
regw_data_i input DATA_W ALU result;
stall_mem output 1 stall request to pipeline;
write_o output 1 register-write enable out;
regw_addr_o output 5 destination out;
regw_data_o output DATA_W write-back data;
ram_en output 1 byte access issue;
ram_we output 1 1 = write;
ram_addr output ADDR_W byte address;
ram_wdata output 8 write byte;
ram_grant input 1 arbiter grant; issue counts only when ram_en and ram_grant both high;
ram_rdata input 8 read byte, valid RAM_LAT cycles after a granted read issue.

Function
REQ-003 SHALL derive byte count N = min(length, DATA_W/8); N = 0 completes with no RAM access, regw_data_o = 0.
REQ-004 SHALL use FSM states IDLE, LOAD, STORE, DONE; separate buffer-drain engine when STORE_BUF=1.
REQ-005 Load in IDLE: SHALL issue byte 0 (addr) combinationally in the same cycle, go to LOAD, and issue byte k at addr+k in successive granted cycles; ram_grant low holds the issue counter.
REQ-006 SHALL track in-flight reads with a RAM_LAT-deep valid shift register and place each returned byte little-endian at bits 8k+7:8k.
REQ-007 After the last byte returns: SHALL go to DONE; in DONE, stall_mem = 0, regw_data_o = assembled value, zero-extended, or sign-extended from bit 8N-1 when signed_ = 1 and N < DATA_W/8; then return to IDLE.
REQ-008 Load latency with grant held high: stall_mem high for N+RAM_LAT cycles, starting in the request cycle.
REQ-009 Store with STORE_BUF=0: SHALL issue bytes data[8k+7:8k] in granted cycles (ram_we=1), enter DONE after the last granted byte; stall_mem high for N cycles with grant held high.
REQ-010 Store with STORE_BUF=1 and buffer empty: SHALL capture addr/data/N at the clock edge, stall_mem = 0 in the request cycle, and drain the bytes in the background.
REQ-011 Any load or store while the buffer is valid: SHALL hold stall_mem high until drain completes, then proceed per REQ-005/REQ-009/REQ-010; the buffer goes empty on the cycle after its last granted byte.
REQ-012 No load/store: regw_data_o = regw_data_i, stall_mem = 0; drain continues.
REQ-013 write_o = write_i and regw_addr_o = regw_addr_i whenever not in reset; the pipeline holds inputs stable while stall_mem = 1.
REQ-014 At most one RAM issue per cycle; the drain engine has priority only while the FSM is IDLE and stalled on it.
REQ-015 ram_addr SHALL wrap modulo 2^ADDR_W when addr+k overflows.
REQ-016 load and store both high: SHALL treat the request as a load.

Reset
REQ-017 reset high SHALL asynchronously force FSM to IDLE, clear counters, valid shift register and store buffer (pending store discarded), and drive ram_en = 0, ram_we = 0, stall_mem = 0, write_o = 0, regw_addr_o = 0, regw_data_o = 0.
REQ-018 Reset mid-transfer SHALL ignore late ram_rdata; the first request after release starts fresh.

Verification
REQ-019 Load length=4, addr=0x100, bytes 11,22,33,44, grant=1, RAM_LAT=2 -> stall 6 cycles, then regw_data_o = 0x44332211.
REQ-020 Load length=1, signed_=1, byte 0x80 -> 0xFFFFFF80; with signed_=0 -> 0x00000080.
REQ-021 STORE_BUF=1: store 0xDEADBEEF at 0x200, then load the same address next cycle -> store stall 0, load stalls until 4 bytes drained, returns 0xDEADBEEF.
REQ-022 Load length=2 with grant low 3 cycles after the first byte -> stall extended by 3, result correct.
REQ-023 reset asserted mid-load at cycle 2 -> ram_en low immediately, outputs 0; a subsequent load returns correct data.
REQ-024 addr=0xFFFFFFFE, length=4 -> ram_addr sequence FFFFFFFE, FFFFFFFF, 0, 1.

Source files
------------

// File: rtl/stage_mem_seq.sv
// -----------------------------------------------------------------------------
// stage_mem_seq
//   Memory stage of the pipeline. It turns word-sized loads and stores into a
//   sequence of single-byte accesses on a shared byte RAM, reassembles load
//   data little-endian and sign/zero-extends it for write-back. With
//   STORE_BUF=1 a one-entry posted store buffer lets stores retire without
//   stalling while their bytes drain in the background.
//
// Parameters
//   ADDR_W    byte address width
//   DATA_W    register width (multiple of 8)
//   RAM_LAT   byte-RAM read latency in cycles (>= 1)
//   STORE_BUF 1 = posted one-entry store buffer, 0 = blocking stores
//
// Ports
//   clk, reset                 clock (rising edge), async active-high reset
//   load, store                request strobes (both high = load)
//   addr, data, length         byte address, store data, byte count
//   signed_                    sign-extend a short load
//   write_i, regw_addr_i,
//   regw_data_i                write-back controls / ALU result from upstream
//   stall_mem                  stall request to the pipeline
//   write_o, regw_addr_o,
//   regw_data_o                write-back controls / data downstream
//   ram_en, ram_we, ram_addr,
//   ram_wdata                  byte access issue (counts when ram_grant high)
//   ram_grant                  arbiter grant
//   ram_rdata                  read byte, valid RAM_LAT cycles after issue
// -----------------------------------------------------------------------------
module stage_mem_seq #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int RAM_LAT   = 2,
   parameter int STORE_BUF = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              store,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data,
   input  logic [2:0]        length,
   input  logic              signed_,
   input  logic              write_i,
   input  logic [4:0]        regw_addr_i,
   input  logic [DATA_W-1:0] regw_data_i,
   output logic              stall_mem,
   output logic              write_o,
   output logic [4:0]        regw_addr_o,
   output logic [DATA_W-1:0] regw_data_o,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   input  logic              ram_grant,
   input  logic [7:0]        ram_rdata
);

   localparam int unsigned NB     = DATA_W / 8;
   localparam int unsigned CW     = $clog2(NB + 1);
   localparam bit          BUF_EN = (STORE_BUF != 0);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOAD  = 2'd1;
   localparam logic [1:0] STORE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]         state, state_nx;
   logic [CW-1:0]      n_bytes;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [CW-1:0]      rcnt;
   logic [CW-1:0]      fsm_idx;
   logic [RAM_LAT-1:0] vsr;
   logic               rd_issue, rd_ret;
   logic [DATA_W-1:0]  asm_q, asm_merged, ld_ext;
   logic               fsm_en, fsm_we;
   logic               start, capture, zero_wb, stall_c;
   logic               req, is_ld, sgn;

   logic               sb_valid;
   logic [ADDR_W-1:0]  sb_addr;
   logic [DATA_W-1:0]  sb_data;
   logic [CW-1:0]      sb_n, sb_cnt;

   function automatic logic [7:0] byte_at(input logic [DATA_W-1:0] v,
                                          input logic [CW-1:0]     idx);
      logic [7:0] r;
      r = 8'h00;
      for (int unsigned b = 0; b < NB; b++)
         if (CW'(b) == idx) r = v[8*b +: 8];
      return r;
   endfunction

   assign req    = load | store;
   assign is_ld  = load;
   assign rd_ret = vsr[RAM_LAT-1];

   // effective byte count, clamped to the register width
   always_comb begin
      n_bytes = (32'(length) > NB) ? CW'(NB) : CW'(length);
   end

   // Sequencer: the FSM only ever issues while the store buffer is empty, so
   // the drain engine never competes with it for the RAM port.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      fsm_en   = 1'b0;
      fsm_we   = 1'b0;
      fsm_idx  = cnt;
      start    = 1'b0;
      capture  = 1'b0;
      zero_wb  = 1'b0;
      stall_c  = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (sb_valid) begin
                  stall_c = 1'b1;
               end else if (n_bytes == '0) begin
                  zero_wb = 1'b1;
               end else if (is_ld) begin
                  stall_c  = 1'b1;
                  fsm_en   = 1'b1;
                  fsm_idx  = '0;
                  start    = 1'b1;
                  state_nx = LOAD;
                  cnt_nx   = ram_grant ? CW'(1) : '0;
               end else if (BUF_EN) begin
                  capture = 1'b1;
               end else begin
                  stall_c = 1'b1;
                  fsm_en  = 1'b1;
                  fsm_we  = 1'b1;
                  fsm_idx = '0;
                  start   = 1'b1;
                  if (ram_grant && n_bytes == CW'(1)) begin
                     state_nx = DONE;
                  end else begin
                     state_nx = STORE;
                     cnt_nx   = ram_grant ? CW'(1) : '0;
                  end
               end
            end
         end
         LOAD: begin
            stall_c = 1'b1;
            if (cnt < n_bytes) begin
               fsm_en = 1'b1;
               if (ram_grant) cnt_nx = cnt + CW'(1);
            end
            if (rd_ret && rcnt == n_bytes - CW'(1)) state_nx = DONE;
         end
         STORE: begin
            stall_c = 1'b1;
            fsm_en  = 1'b1;
            fsm_we  = 1'b1;
            if (ram_grant) begin
               if (cnt == n_bytes - CW'(1)) state_nx = DONE;
               else                         cnt_nx   = cnt + CW'(1);
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   assign rd_issue = fsm_en & ~fsm_we & ~sb_valid & ram_grant;

   // drop the returning byte into lane rcnt
   always_comb begin
      asm_merged = asm_q;
      for (int unsigned b = 0; b < NB; b++)
         if (CW'(b) == rcnt) asm_merged[8*b +: 8] = ram_rdata;
   end

   // extension: sign bit is the top bit of the last loaded byte
   always_comb begin
      ld_ext = '0;
      sgn    = 1'b0;
      for (int unsigned b = 0; b < NB; b++) begin
         if (CW'(b) < n_bytes)       ld_ext[8*b +: 8] = asm_q[8*b +: 8];
         if (CW'(b + 1) == n_bytes)  sgn = asm_q[8*b + 7];
      end
      if (signed_ && sgn)
         for (int unsigned b = 0; b < NB; b++)
            if (CW'(b) >= n_bytes) ld_ext[8*b +: 8] = 8'hFF;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         rcnt     <= '0;
         vsr      <= '0;
         asm_q    <= '0;
         sb_valid <= 1'b0;
         sb_addr  <= '0;
         sb_data  <= '0;
         sb_n     <= '0;
         sb_cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         vsr   <= (vsr << 1) | RAM_LAT'(rd_issue);
         if (start) begin
            rcnt  <= '0;
            asm_q <= '0;
         end else if (rd_ret) begin
            rcnt  <= rcnt + CW'(1);
            asm_q <= asm_merged;
         end
         if (sb_valid && ram_grant) begin
            if (sb_cnt == sb_n - CW'(1)) sb_valid <= 1'b0;
            sb_cnt <= sb_cnt + CW'(1);
         end
         if (capture) begin
            sb_valid <= 1'b1;
            sb_addr  <= addr;
            sb_data  <= data;
            sb_n     <= n_bytes;
            sb_cnt   <= '0;
         end
      end
   end

   // everything visible is forced quiet while reset is asserted
   always_comb begin
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      stall_mem   = 1'b0;
      write_o     = 1'b0;
      regw_addr_o = '0;
      regw_data_o = '0;
      if (!reset) begin
         write_o     = write_i;
         regw_addr_o = regw_addr_i;
         stall_mem   = stall_c;
         if (sb_valid) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = sb_addr + ADDR_W'(sb_cnt);
            ram_wdata = byte_at(sb_data, sb_cnt);
         end else if (fsm_en) begin
            ram_en   = 1'b1;
            ram_we   = fsm_we;
            ram_addr = addr + ADDR_W'(fsm_idx);
            if (fsm_we) ram_wdata = byte_at(data, fsm_idx);
         end
         if (state == DONE)  regw_data_o = ld_ext;
         else if (zero_wb)   regw_data_o = '0;
         else                regw_data_o = regw_data_i;
      end
   end

endmodule

// File: tb/tb_stage_mem_seq.sv
// -----------------------------------------------------------------------------
// tb_stage_mem_seq
//   Bench for stage_mem_seq (defaults: 32-bit, RAM_LAT=2, STORE_BUF=1).
//   A byte RAM with configurable latency and a grant driver surround the DUT.
//   Directed vectors come from a table; multi-cycle corners (wrap, reset
//   mid-load, pass-through) are hand sequences; random traffic is compared
//   against a flat byte-array reference of memory contents.
// -----------------------------------------------------------------------------
module tb_stage_mem_seq;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        load, store, signed_, write_i;
   logic [31:0] addr, data, regw_data_i;
   logic [2:0]  length;
   logic [4:0]  regw_addr_i;
   logic        stall_mem, write_o;
   logic [4:0]  regw_addr_o;
   logic [31:0] regw_data_o;
   logic        ram_en, ram_we, ram_grant;
   logic [31:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;

   always #5 clk = ~clk;

   stage_mem_seq #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(LAT), .STORE_BUF(1)) dut (
      .clk(clk), .reset(reset), .load(load), .store(store), .addr(addr),
      .data(data), .length(length), .signed_(signed_), .write_i(write_i),
      .regw_addr_i(regw_addr_i), .regw_data_i(regw_data_i),
      .stall_mem(stall_mem), .write_o(write_o), .regw_addr_o(regw_addr_o),
      .regw_data_o(regw_data_o), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_grant(ram_grant),
      .ram_rdata(ram_rdata)
   );

   // byte RAM environment (low 16 address bits select the cell)
   logic [7:0]  mem [0:65535];
   logic [7:0]  pipe [LAT];
   logic [31:0] rd_log [$];

   assign ram_rdata = pipe[LAT-1];

   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
      if (ram_en && ram_grant && !ram_we) begin
         pipe[0] <= mem[ram_addr[15:0]];
         rd_log.push_back(ram_addr);
      end else begin
         pipe[0] <= 8'($urandom);
      end
      if (ram_en && ram_grant && ram_we) mem[ram_addr[15:0]] <= ram_wdata;
   end

   // reference memory for the random window 0x1000..0x1043
   logic [7:0] ref_mem [68];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] len,
                                            input logic sg);
      int n;
      logic [31:0] v;
      n = (len > 3'd4) ? 4 : int'(len);
      v = 32'd0;
      for (int k = 0; k < n; k++)
         v = v | (32'(ref_mem[int'(a - 32'h1000) + k]) << (8 * k));
      if (sg && n > 0 && n < 4 && v[8*n-1])
         v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] len);
      int n;
      n = (len > 3'd4) ? 4 : int'(len);
      for (int k = 0; k < n; k++)
         ref_mem[int'(a - 32'h1000) + k] = d[8*k +: 8];
   endtask

   // Applies one request, holding it while stall_mem is high; grant in the
   // i-th cycle of the request is gm[i] (1 beyond bit 31).
   task automatic run_op(input logic ld, input logic st, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] len, input logic sg,
                         input logic [31:0] gm, output int stalls,
                         output logic [31:0] res, output logic [5:0] side);
      int i;
      load = ld; store = st; addr = a; data = d; length = len; signed_ = sg;
      ram_grant = gm[0];
      stalls = 0; i = 0; res = '0; side = '0;
      forever begin
         @(negedge clk);
         if (!stall_mem) begin
            res  = regw_data_o;
            side = {write_o, regw_addr_o};
            break;
         end
         stalls++;
         if (stalls > 300) begin
            checks++; errors++;
            $display("FAIL timeout: stall_mem high for %0d cycles, required to drop", stalls);
            break;
         end
         @(posedge clk); #1;
         i++;
         ram_grant = (i < 32) ? gm[i] : 1'b1;
      end
      @(posedge clk); #1;
      load = 1'b0; store = 1'b0; ram_grant = 1'b1;
   endtask

   typedef struct {
      string       name;
      logic        ld;
      logic        st;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  len;
      logic        sg;
      logic [31:0] gm;
      int          exp_stall;
      logic        chk_res;
      logic [31:0] exp_res;
   } vec_t;

   vec_t vt [$];

   task automatic add(input string nm, input logic ld, input logic st, input logic [31:0] a,
                      input logic [31:0] d, input logic [2:0] len, input logic sg,
                      input logic [31:0] gm, input int es, input logic cr,
                      input logic [31:0] er);
      vec_t v;
      v.name = nm; v.ld = ld; v.st = st; v.a = a; v.d = d; v.len = len; v.sg = sg;
      v.gm = gm; v.exp_stall = es; v.chk_res = cr; v.exp_res = er;
      vt.push_back(v);
   endtask

   initial begin
      int          stalls;
      logic [31:0] res;
      logic [5:0]  side;
      logic [7:0]  b;

      // RAM seeding
      mem[16'h0100] <= 8'h11; mem[16'h0101] <= 8'h22;
      mem[16'h0102] <= 8'h33; mem[16'h0103] <= 8'h44;
      mem[16'h0300] <= 8'h80;
      mem[16'hFFFE] <= 8'hA1; mem[16'hFFFF] <= 8'hB2;
      mem[16'h0000] <= 8'hC3; mem[16'h0001] <= 8'hD4;
      for (int i = 0; i < LAT; i++) pipe[i] <= 8'h00;
      for (int i = 0; i < 68; i++) begin
         b = 8'($urandom);
         ref_mem[i] = b;
         mem[16'h1000 + 16'(i)] <= b;
      end

      // reset state, with a load already presented
      reset = 1'b1; load = 1'b1; store = 1'b0; addr = 32'h100; data = '0;
      length = 3'd4; signed_ = 1'b0; write_i = 1'b1; regw_addr_i = 5'd9;
      regw_data_i = 32'hCAFE0001; ram_grant = 1'b1;
      #2;
      check("rst_ram_en",    32'(ram_en), 32'd0);
      check("rst_ram_we",    32'(ram_we), 32'd0);
      check("rst_stall",     32'(stall_mem), 32'd0);
      check("rst_write_o",   32'(write_o), 32'd0);
      check("rst_regw_addr", 32'(regw_addr_o), 32'd0);
      check("rst_regw_data", regw_data_o, 32'd0);
      load = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      //   name          ld    st    addr          data          len   sg    grant mask    stall chk  result
      add("ld4",        1'b1, 1'b0, 32'h100,      32'h0,        3'd4, 1'b0, 32'hFFFFFFFF, 6,  1'b1, 32'h44332211);
      add("ld1s",       1'b1, 1'b0, 32'h300,      32'h0,        3'd1, 1'b1, 32'hFFFFFFFF, 3,  1'b1, 32'hFFFFFF80);
      add("ld1u",       1'b1, 1'b0, 32'h300,      32'h0,        3'd1, 1'b0, 32'hFFFFFFFF, 3,  1'b1, 32'h00000080);
      add("ldgap",      1'b1, 1'b0, 32'h100,      32'h0,        3'd2, 1'b0, 32'hFFFFFFF1, 7,  1'b1, 32'h00002211);
      add("ldclamp",    1'b1, 1'b0, 32'h100,      32'h0,        3'd7, 1'b1, 32'hFFFFFFFF, 6,  1'b1, 32'h44332211);
      add("ld0",        1'b1, 1'b0, 32'h100,      32'h0,        3'd0, 1'b1, 32'hFFFFFFFF, 0,  1'b1, 32'h00000000);
      add("ld2s_pos",   1'b1, 1'b0, 32'h102,      32'h0,        3'd2, 1'b1, 32'hFFFFFFFF, 4,  1'b1, 32'h00004433);
      add("ldwrap2s",   1'b1, 1'b0, 32'hFFFFFFFE, 32'h0,        3'd2, 1'b1, 32'hFFFFFFFF, 4,  1'b1, 32'hFFFFB2A1);
      add("ldst_both",  1'b1, 1'b1, 32'h100,      32'h0,        3'd4, 1'b0, 32'hFFFFFFFF, 6,  1'b1, 32'h44332211);
      add("st_post",    1'b0, 1'b1, 32'h200,      32'hDEADBEEF, 3'd4, 1'b0, 32'hFFFFFFFF, 0,  1'b0, 32'h0);
      add("ld_drain4",  1'b1, 1'b0, 32'h200,      32'h0,        3'd4, 1'b0, 32'hFFFFFFFF, 10, 1'b1, 32'hDEADBEEF);
      add("st2_post",   1'b0, 1'b1, 32'h400,      32'hAAAA5566, 3'd2, 1'b0, 32'hFFFFFFFF, 0,  1'b0, 32'h0);
      add("st_busy",    1'b0, 1'b1, 32'h404,      32'h0BADF00D, 3'd4, 1'b0, 32'hFFFFFFFF, 2,  1'b0, 32'h0);
      add("ld_drain_b", 1'b1, 1'b0, 32'h400,      32'h0,        3'd2, 1'b0, 32'hFFFFFFFF, 8,  1'b1, 32'h00005566);
      add("ld_after",   1'b1, 1'b0, 32'h404,      32'h0,        3'd4, 1'b1, 32'hFFFFFFFF, 6,  1'b1, 32'h0BADF00D);

      foreach (vt[i]) begin
         write_i = i[0]; regw_addr_i = 5'(i); regw_data_i = $urandom;
         run_op(vt[i].ld, vt[i].st, vt[i].a, vt[i].d, vt[i].len, vt[i].sg, vt[i].gm,
                stalls, res, side);
         check({vt[i].name, "_stall"}, 32'(stalls), 32'(vt[i].exp_stall));
         if (vt[i].chk_res) check({vt[i].name, "_data"}, res, vt[i].exp_res);
         check({vt[i].name, "_wb_ctl"}, 32'(side), 32'({i[0], 5'(i)}));
      end

      // address wrap across the top of the address space
      rd_log.delete();
      run_op(1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 3'd4, 1'b0, 32'hFFFFFFFF, stalls, res, side);
      check("wrap_data",  res, 32'hD4C3B2A1);
      check("wrap_stall", 32'(stalls), 32'd6);
      check("wrap_count", 32'(rd_log.size()), 32'd4);
      if (rd_log.size() == 4) begin
         check("wrap_a0", rd_log[0], 32'hFFFFFFFE);
         check("wrap_a1", rd_log[1], 32'hFFFFFFFF);
         check("wrap_a2", rd_log[2], 32'h00000000);
         check("wrap_a3", rd_log[3], 32'h00000001);
      end

      // reset in the middle of a load
      write_i = 1'b1; regw_addr_i = 5'd3; regw_data_i = 32'h55;
      load = 1'b1; addr = 32'h100; length = 3'd4; signed_ = 1'b0; ram_grant = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("mid_ram_en_before", 32'(ram_en), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_ram_en",    32'(ram_en), 32'd0);
      check("mid_rst_stall",     32'(stall_mem), 32'd0);
      check("mid_rst_write_o",   32'(write_o), 32'd0);
      check("mid_rst_regw_addr", 32'(regw_addr_o), 32'd0);
      check("mid_rst_regw_data", regw_data_o, 32'd0);
      load = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      run_op(1'b1, 1'b0, 32'h100, 32'h0, 3'd4, 1'b0, 32'hFFFFFFFF, stalls, res, side);
      check("post_rst_data",  res, 32'h44332211);
      check("post_rst_stall", 32'(stalls), 32'd6);

      // no request: pass-through
      write_i = 1'b1; regw_addr_i = 5'd17; regw_data_i = 32'h12345678;
      @(negedge clk);
      check("pass_stall",     32'(stall_mem), 32'd0);
      check("pass_write_o",   32'(write_o), 32'd1);
      check("pass_regw_addr", 32'(regw_addr_o), 32'd17);
      check("pass_regw_data", regw_data_o, 32'h12345678);
      @(posedge clk); #1;

      // random traffic in the 0x1000 window
      for (int t = 0; t < 200; t++) begin
         int          r;
         logic [31:0] a, d, gm;
         logic [2:0]  len;
         logic        sg, ld, st;
         r   = $urandom_range(0, 9);
         a   = 32'h1000 + 32'($urandom_range(0, 60));
         len = 3'($urandom_range(0, 7));
         sg  = 1'($urandom);
         d   = $urandom;
         gm  = $urandom;
         write_i = 1'($urandom); regw_addr_i = 5'($urandom); regw_data_i = $urandom;
         if (r < 8) begin
            ld = (r < 4);
            st = (r >= 3);
            run_op(ld, st, a, d, len, sg, gm, stalls, res, side);
            if (ld) check("rnd_load", res, ref_load(a, len, sg));
            else    ref_store(a, d, len);
         end else begin
            load = 1'b0; store = 1'b0; ram_grant = 1'($urandom);
            @(negedge clk);
            check("rnd_idle_data",  regw_data_o, regw_data_i);
            check("rnd_idle_stall", 32'(stall_mem), 32'd0);
            @(posedge clk); #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
